cond_unit: RTL and testbench

// - Condition/flag stage directly downstream of the ALU in the multi-cycle ARM datapath.
// - Holds architectural NZCV flags written from alu_flags; latches ALU result into ALUOut register.
// - Evaluates the instruction cond field once per instruction, holds result (CondEx) for the

---
 rtl/cond_unit.sv | 88 ++++++++
 tb/tb_cond_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Condition/flag stage behind the ALU: NZCV flag register, ALUOut latch, held CondEx and write gating.
// Optional COND_SKIP_CNT_EN adds a saturating count of instructions whose condition failed.
module cond_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  input  logic [3:0]       cond,
  input  logic             cond_latch,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             next_pc,
  input  logic             reg_w,
  input  logic             mem_w,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags,
  output logic             cond_ex,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_write
`ifdef COND_SKIP_CNT_EN
  ,
  output logic [CNT_W-1:0] skip_cnt
`endif
);

  logic n, z, c, v;
  logic cond_pass;

  assign {n, z, c, v} = flags;

  // Decode always sees the committed flags, never the ones being written this edge.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = z;
      4'h1: cond_pass = ~z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = ~c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = ~n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = ~v;
      4'h8: cond_pass = c & ~z;
      4'h9: cond_pass = ~c | z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = ~z & (n == v);
      4'hD: cond_pass = z | (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alu_out <= '0;
      flags   <= 4'b0000;
      cond_ex <= 1'b0;
    end else begin
      alu_out <= alu_result;
      if (cond_latch)
        cond_ex <= cond_pass;
      // Flag writes are qualified by the cond_ex of the instruction now finishing.
      if (cond_ex && flag_w[1])
        flags[3:2] <= alu_flags[3:2];
      if (cond_ex && flag_w[0])
        flags[1:0] <= alu_flags[1:0];
    end
  end

  assign pc_write  = (pcs & cond_ex) | next_pc;
  assign reg_write = reg_w & cond_ex;
  assign mem_write = mem_w & cond_ex;

`ifdef COND_SKIP_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      skip_cnt <= '0;
    else if (cond_latch && !cond_pass && (skip_cnt != {CNT_W{1'b1}}))
      skip_cnt <= skip_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_cond_unit;
`ifdef COND_SKIP_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags, cond;
  logic        cond_latch, pcs, next_pc, reg_w, mem_w;
  logic [1:0]  flag_w;
  logic [31:0] alu_out;
  logic [3:0]  flags;
  logic        cond_ex, pc_write, reg_write, mem_write;
`ifdef COND_SKIP_CNT_EN
  logic [CW-1:0] skip_cnt;
`endif

  typedef struct {
    string       name;
    logic [3:0]  flags;
    logic        ce, pcw, rw, mw;
    logic [31:0] aout;
    logic [CW-1:0] skip;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;
  int nstep  = 0;
  logic [CW-1:0] skip_m = '0;

  cond_unit #(.WIDTH(32), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .alu_result(alu_result), .alu_flags(alu_flags),
    .cond(cond), .cond_latch(cond_latch), .flag_w(flag_w), .pcs(pcs), .next_pc(next_pc),
    .reg_w(reg_w), .mem_w(mem_w), .alu_out(alu_out), .flags(flags), .cond_ex(cond_ex),
    .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write)
`ifdef COND_SKIP_CNT_EN
    , .skip_cnt(skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then queue the expected post-edge outputs.
  task automatic step(input string nm, input logic rn, input logic [3:0] c, input logic l,
                      input logic [1:0] fw, input logic [3:0] af, input logic p, input logic np,
                      input logic rw, input logic mw, input logic [3:0] ef, input logic ece,
                      input logic epw, input logic erw, input logic emw);
    exp_t e;
    logic [31:0] val;
    @(negedge clk);
    #1;
    nstep++;
    val = 32'h1357_0000 ^ (nstep * 32'h0101_0101);
    reset_n = rn; cond = c; cond_latch = l; flag_w = fw; alu_flags = af;
    pcs = p; next_pc = np; reg_w = rw; mem_w = mw; alu_result = val;
    @(posedge clk);
    #1;
    if (!rn) skip_m = '0;
    else if (l && !ece && skip_m != {CW{1'b1}}) skip_m = skip_m + 1'b1;
    e.name = nm; e.flags = ef; e.ce = ece; e.pcw = epw; e.rw = erw; e.mw = emw;
    e.aout = rn ? val : 32'h0; e.skip = skip_m;
    q.push_back(e);
  endtask

  // Sweep all 16 cond codes against fixed flags; tbl bit i is the hand-decoded result for cond i.
  task automatic sweep(input logic [15:0] tbl, input logic [3:0] f);
    for (int i = 0; i < 16; i++)
      step($sformatf("cond%0h_f%b", i, f), 1, i[3:0], 1, 2'b00, 4'h0, 1, 0, 1, 1,
           f, tbl[i], tbl[i], tbl[i], tbl[i]);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({flags, cond_ex, pc_write, reg_write, mem_write, alu_out} !==
          {e.flags, e.ce, e.pcw, e.rw, e.mw, e.aout}) begin
        fails++;
        $display("FAIL %s: got flags=%b ce=%b pcw=%b rw=%b mw=%b alu_out=%h, want flags=%b ce=%b pcw=%b rw=%b mw=%b alu_out=%h",
                 e.name, flags, cond_ex, pc_write, reg_write, mem_write, alu_out,
                 e.flags, e.ce, e.pcw, e.rw, e.mw, e.aout);
      end
`ifdef COND_SKIP_CNT_EN
      checks++;
      if (skip_cnt !== e.skip) begin
        fails++;
        $display("FAIL %s_skip: got skip_cnt=%0d, want %0d", e.name, skip_cnt, e.skip);
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 0; cond = 0; cond_latch = 0; flag_w = 0; alu_flags = 0;
    pcs = 0; next_pc = 0; reg_w = 0; mem_w = 0; alu_result = 0;
    //     name            rn c    l fw     af     p np rw mw  flags  ce pw rw mw
    step("reset0",         0, 4'h0, 0, 2'b11, 4'hF, 1, 1, 1, 1, 4'b0000, 0, 1, 0, 0);
    step("reset1",         0, 4'h0, 0, 2'b11, 4'hF, 1, 1, 1, 1, 4'b0000, 0, 1, 0, 0);
    step("al_latch",       1, 4'hE, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0);
    step("subs",           1, 4'hE, 0, 2'b11, 4'h6, 0, 0, 1, 0, 4'b0110, 1, 0, 1, 0);
    step("eq_pass",        1, 4'h0, 1, 2'b00, 4'h0, 0, 0, 0, 1, 4'b0110, 1, 0, 0, 1);
    step("ne_fail",        1, 4'h1, 1, 2'b00, 4'h0, 1, 0, 1, 1, 4'b0110, 0, 0, 0, 0);
    step("squash_flags",   1, 4'h1, 0, 2'b11, 4'hF, 1, 1, 1, 1, 4'b0110, 0, 1, 0, 0);
    step("al_latch2",      1, 4'hE, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'b0110, 1, 0, 0, 0);
    step("all_flags",      1, 4'hE, 0, 2'b11, 4'hF, 1, 0, 0, 0, 4'b1111, 1, 1, 0, 0);
    step("nz_only",        1, 4'hE, 0, 2'b10, 4'h0, 0, 0, 0, 0, 4'b0011, 1, 0, 0, 0);
    step("cv_only",        1, 4'hE, 0, 2'b01, 4'hE, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 0);
    sweep(16'h55A6, 4'b0010);
    step("al_latch3",      1, 4'hE, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 0);
    step("set_1101",       1, 4'hE, 0, 2'b11, 4'hD, 0, 0, 0, 0, 4'b1101, 1, 0, 0, 0);
    sweep(16'h6659, 4'b1101);
    step("al_latch4",      1, 4'hE, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'b1101, 1, 0, 0, 0);
    step("set_1000",       1, 4'hE, 0, 2'b11, 4'h8, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 0);
    sweep(16'h6A9A, 4'b1000);
    step("squash_eq",      1, 4'h0, 1, 2'b00, 4'h0, 1, 0, 1, 1, 4'b1000, 0, 0, 0, 0);
    step("squash_fw",      1, 4'h0, 0, 2'b11, 4'h5, 1, 0, 1, 1, 4'b1000, 0, 0, 0, 0);
    step("al_latch5",      1, 4'hE, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'b1000, 1, 0, 0, 0);
    step("same_edge",      1, 4'h0, 1, 2'b11, 4'h4, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0);
    step("eq_after",       1, 4'h0, 1, 2'b00, 4'h0, 0, 0, 1, 0, 4'b0100, 1, 0, 1, 0);
    step("mid_reset",      0, 4'h0, 0, 2'b00, 4'h0, 1, 0, 1, 1, 4'b0000, 0, 0, 0, 0);
`ifdef COND_SKIP_CNT_EN
    for (int k = 0; k < 5; k++)
      step($sformatf("skip%0d", k), 1, 4'hF, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    step("skip_reset",     0, 4'h0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
`endif
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
